// File: rtl/z80_busrq_arbiter.sv
// z80_busrq_arbiter
//
// Shares the Z80 system bus between NUM_REQ external bus masters. The block
// takes the bus from the CPU with the nBUSRQ/nBUSACK handshake, hands it to
// one master at a time in round-robin order and bounds every tenure with a
// hold timeout. After each tenure nBUSRQ stays high for a guard gap before
// the CPU can be asked again.
//
// Parameters:
//   NUM_REQ   number of requesting masters (2..8)
//   HOLD_MAX  maximum cycles a single grant may be held (>=2)
//   GAP_CYC   idle cycles after release before nBUSRQ may fall again (>=1)
//
// Ports:
//   CLK       system clock, rising edge
//   nRESET    asynchronous active-low reset
//   req       level request per master, held while wanting/holding the bus
//   nBUSACK   CPU bus acknowledge, active low
//   nBUSRQ    CPU bus request, active low, registered
//   gnt       one-hot grant, registered, zero when nobody owns the bus
//   timeout   one-cycle pulse when a grant is forcibly ended
//   busy      high whenever the arbiter is not idle
module z80_busrq_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 64,
  parameter int GAP_CYC  = 2
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [NUM_REQ-1:0] req,
  input  logic               nBUSACK,
  output logic               nBUSRQ,
  output logic [NUM_REQ-1:0] gnt,
  output logic               timeout,
  output logic               busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(HOLD_MAX);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE,
    GAP
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [PW:0]   pick;

  // Returns {found, index} of the first set request bit, searching upward
  // from p and wrapping modulo NUM_REQ. The loop runs backwards so the
  // candidate closest to p is the last one written.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                          input logic [PW-1:0]      p);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(p) + i) % NUM_REQ;
      if (r[j]) res = {1'b1, j[PW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] w);
    return (w == PW'(NUM_REQ - 1)) ? '0 : w + 1'b1;
  endfunction

  assign pick = rr_pick(req, ptr);
  assign busy = (state != IDLE);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      nBUSRQ   <= 1'b1;
      gnt      <= '0;
      timeout  <= 1'b0;
      ptr      <= '0;
      win      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= REQ;
            nBUSRQ <= 1'b0;
          end
        end

        // CPU finishes its machine cycle before acking, so no timeout here.
        REQ: begin
          if (!nBUSACK) begin
            if (pick[PW]) begin
              win      <= pick[PW-1:0];
              gnt      <= ONE << pick[PW-1:0];
              hold_cnt <= '0;
              state    <= GRANT;
            end else begin
              // Requester vanished before the ack: hand the bus straight back.
              nBUSRQ <= 1'b1;
              state  <= RELEASE;
            end
          end
        end

        GRANT: begin
          if (nBUSACK) begin
            // CPU took the bus back under us: drop the grant, no timeout.
            gnt    <= '0;
            nBUSRQ <= 1'b1;
            ptr    <= next_idx(win);
            state  <= RELEASE;
          end else if (!req[win] || hold_cnt == HW'(HOLD_MAX - 1)) begin
            // A simultaneous request drop and limit hit counts as a normal
            // end, which is exactly when req[win] is already low.
            gnt     <= '0;
            nBUSRQ  <= 1'b1;
            ptr     <= next_idx(win);
            timeout <= req[win];
            state   <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (nBUSACK) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_busrq_arbiter.sv
module tb_z80_busrq_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int HOLD_MAX = 64;
  localparam int GAP_CYC  = 2;

  logic               CLK;
  logic               nRESET;
  logic [NUM_REQ-1:0] req;
  logic               nBUSACK;
  logic               nBUSRQ;
  logic [NUM_REQ-1:0] gnt;
  logic               timeout;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;   // reference round-robin pointer

  z80_busrq_arbiter #(
    .NUM_REQ (NUM_REQ),
    .HOLD_MAX(HOLD_MAX),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .req    (req),
    .nBUSACK(nBUSACK),
    .nBUSRQ (nBUSRQ),
    .gnt    (gnt),
    .timeout(timeout),
    .busy   (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requesting master at or after p, wrapping; -1 if none.
  function automatic int rr_ref(input logic [NUM_REQ-1:0] v, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // One complete bus tenure starting from IDLE:
  //   r     request pattern raised in IDLE
  //   d     cycles the CPU waits before acking
  //   r2    request pattern present on the ack edge (0 = abandoned)
  //   l     full granted cycles the winner keeps req high before dropping it
  //   s     cycles nBUSACK stays low after release
  //   rnext request pattern driven during the gap (must be ignored)
  task automatic tenure(input logic [3:0] r, input int d, input logic [3:0] r2,
                        input int l, input int s, input logic [3:0] rnext);
    int         w;
    int         dur;
    logic       exp_to;
    logic [3:0] oh;
    req = r;
    tick();
    chk("req_start", 32'({nBUSRQ, gnt, busy}), 32'({1'b0, 4'b0000, 1'b1}));
    for (int i = 0; i < d; i++) begin
      tick();
      chk("req_wait", 32'({nBUSRQ, gnt, busy}), 32'({1'b0, 4'b0000, 1'b1}));
    end
    req     = r2;
    nBUSACK = 1'b0;
    tick();
    w = rr_ref(r2, ptr_m);
    if (w < 0) begin
      chk("abandon", 32'({nBUSRQ, gnt, timeout, busy}), 32'({1'b1, 4'b0000, 1'b0, 1'b1}));
    end else begin
      oh = 4'b0001 << w;
      chk("grant", 32'({nBUSRQ, gnt, timeout}), 32'({1'b0, oh, 1'b0}));
      dur    = (l + 1 < HOLD_MAX) ? l + 1 : HOLD_MAX;
      exp_to = (l + 1 > HOLD_MAX);
      for (int k = 1; k <= dur; k++) begin
        req = (r2 & ~oh) | ((k <= l) ? oh : 4'b0000);
        tick();
        if (k < dur)
          chk("hold", 32'({nBUSRQ, gnt, timeout}), 32'({1'b0, oh, 1'b0}));
        else
          chk("end", 32'({nBUSRQ, gnt, timeout, busy}), 32'({1'b1, 4'b0000, exp_to, 1'b1}));
      end
      ptr_m = (w + 1) % NUM_REQ;
    end
    for (int i = 0; i < s; i++) begin
      tick();
      chk("rel_stuck", 32'({nBUSRQ, gnt, timeout, busy}), 32'({1'b1, 4'b0000, 1'b0, 1'b1}));
    end
    nBUSACK = 1'b1;
    req     = rnext;
    tick();
    for (int j = 0; j < GAP_CYC; j++) begin
      chk("gap", 32'({nBUSRQ, gnt, timeout, busy}), 32'({1'b1, 4'b0000, 1'b0, 1'b1}));
      tick();
    end
    chk("idle_again", 32'({nBUSRQ, gnt, busy}), 32'({1'b1, 4'b0000, 1'b0}));
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] r2;
    int         l;
    int         mode;

    nRESET  = 1'b0;
    req     = '0;
    nBUSACK = 1'b1;
    repeat (3) tick();
    chk("reset", 32'({nBUSRQ, gnt, timeout, busy}), 32'({1'b1, 4'b0000, 1'b0, 1'b0}));
    nRESET = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_noreq", 32'({nBUSRQ, gnt, busy}), 32'({1'b1, 4'b0000, 1'b0}));
    end

    // Single master with a 3-cycle ack delay, 5-cycle grant.
    tenure(4'b0001, 2, 4'b0001, 4, 1, 4'b0000);

    // Reset while master 3 owns the bus; pointer must restart at 0.
    req = 4'b1000;
    tick();
    nBUSACK = 1'b0;
    tick();
    chk("rst_pre_gnt", 32'(gnt), 32'(4'b1000));
    #2;
    nRESET = 1'b0;
    #1;
    chk("rst_async", 32'({nBUSRQ, gnt, timeout, busy}), 32'({1'b1, 4'b0000, 1'b0, 1'b0}));
    nBUSACK = 1'b1;
    req     = '0;
    tick();
    nRESET = 1'b1;
    ptr_m  = 0;
    tick();

    // Abandoned request, then the pointer must still be where it was.
    tenure(4'b0010, 1, 4'b0000, 0, 0, 4'b0000);
    tenure(4'b0011, 0, 4'b0011, 3, 0, 4'b0000);

    // Round-robin among three persistent requesters.
    for (int i = 0; i < 4; i++) tenure(4'b1011, 0, 4'b1011, 3, 0, 4'b1011);

    // Hold timeout, then re-grant to the sole requester.
    tenure(4'b0100, 0, 4'b0100, 200, 2, 4'b0100);
    tenure(4'b0100, 1, 4'b0100, 2, 0, 4'b0000);

    // Limit boundaries: drop on the limit edge, and one cycle before it.
    tenure(4'b0001, 0, 4'b0001, HOLD_MAX - 1, 0, 4'b0000);
    tenure(4'b0010, 0, 4'b0010, HOLD_MAX - 2, 0, 4'b0000);

    // Ack stuck low after release.
    tenure(4'b1000, 3, 4'b1000, 1, 6, 4'b0000);

    // Randomized tenures.
    for (int n = 0; n < 30; n++) begin
      r    = 4'($urandom_range(1, 15));
      mode = $urandom_range(0, 9);
      if (mode == 0)     r2 = 4'b0000;
      else if (mode < 6) r2 = r;
      else               r2 = 4'($urandom_range(1, 15));
      l = ($urandom_range(0, 9) < 2) ? $urandom_range(HOLD_MAX - 4, HOLD_MAX + 4)
                                     : $urandom_range(0, 8);
      tenure(r, $urandom_range(0, 4), r2, l, $urandom_range(0, 3),
             4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_busrq_arbiter.md
Name: z80_busrq_arbiter

Overview:
- Shares the Z80 system bus between NUM_REQ external bus masters (DMA, video fetch, debug port).
- Uses the CPU's nBUSRQ/nBUSACK handshake to take the bus, grants it to one master at a time in round-robin order, and bounds each tenure with a hold timeout.
- Sits beside z80_top on the z80_if bus; drives nBUSRQ and samples nBUSACK.

Parameters:
- NUM_REQ, 4, number of requesting masters (2..8).
- HOLD_MAX, 64, maximum cycles one grant may be held before forced release (>=2).
- GAP_CYC, 2, idle cycles after release before nBUSRQ may be reasserted (>=1).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- nRESET  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request per master; held high while the master wants or holds the bus.
- nBUSACK  input  1  CPU bus acknowledge, active low.
- nBUSRQ  output  1  CPU bus request, active low, registered.
- gnt  output  NUM_REQ  one-hot grant, registered; all zero when no master owns the bus.
- timeout  output  1  one-cycle pulse on forced release.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (nRESET low, asynchronous) sets:
  - nBUSRQ=1, gnt=0, timeout=0, busy=0
  - state=IDLE, round-robin pointer ptr=0, hold counter=0, gap counter=0.
- Reset mid-operation abandons the tenure immediately. nBUSRQ returns high and gnt clears asynchronously.
- States: IDLE, REQ, GRANT, RELEASE, GAP.
- IDLE:
  - If any req bit is sampled high at edge n: state=REQ and nBUSRQ=0 after edge n (1-cycle latency).
  - Otherwise remain in IDLE.
- REQ:
  - nBUSRQ held low. Wait for nBUSACK sampled low.
  - On that edge, pick the winner: the first set req bit searching ptr, ptr+1, ... modulo NUM_REQ.
  - gnt[winner]=1 after the same edge (1-cycle latency from ack); state=GRANT; hold counter=0.
  - If nBUSACK is low but no req bit is set, go to RELEASE without any grant.
  - No timeout applies in REQ; the CPU always finishes its current machine cycle.
- GRANT:
  - Hold counter increments every cycle that gnt is high.
  - Normal end: req[winner] sampled low → next edge gnt=0, nBUSRQ=1, state=RELEASE, ptr=(winner+1) mod NUM_REQ.
  - Forced end: counter reaches HOLD_MAX-1 with req[winner] still high → same transition, plus timeout=1 for exactly that one cycle. The grant lasts exactly HOLD_MAX cycles.
  - If both ends fall on the same edge, normal end wins and timeout stays 0.
  - Other req bits are ignored during GRANT.
  - nBUSACK going high during GRANT is a protocol error: gnt is dropped immediately and the block goes to RELEASE with no timeout.
- RELEASE:
  - nBUSRQ=1, gnt=0. Wait for nBUSACK sampled high, with no limit.
  - Then state=GAP and gap counter=0.
- GAP:
  - Stay GAP_CYC cycles, then go to IDLE.
  - req is re-evaluated only in IDLE. Back-to-back tenures are therefore separated by at least GAP_CYC+1 cycles with nBUSRQ high.
- Invariants:
  - gnt is one-hot or zero.
  - gnt is nonzero only while nBUSRQ=0 and nBUSACK was sampled low at the previous edge.
  - ptr advances only after a real grant.

Test Plan:
- Single master: req=0001 at cycle 10; CPU acks 3 cycles after nBUSRQ falls → nBUSRQ low at 11, gnt=0001 one cycle after the ack edge. Drop req 5 cycles later → gnt=0 and nBUSRQ=1 next edge; nBUSRQ stays high ≥3 cycles after nBUSACK rises (GAP_CYC=2).
- Round-robin: req=1011 held, each master drops req after 4 granted cycles and re-raises it → grant order 0001, 0010, 1000, 0001; never two grant bits high at once.
- Timeout: req=0100 held permanently, HOLD_MAX=64 → gnt=0100 for exactly 64 cycles, then timeout pulses for 1 cycle. The next tenure grants 0100 again after the gap because it is the only requester.
- Abandoned request: req=0010 pulsed for 1 cycle, ack arrives later with req=0 → no gnt ever asserted, nBUSRQ released, ptr unchanged (next req=0011 grants 0001).
- Reset mid-grant: assert nRESET low asynchronously while gnt=1000 → nBUSRQ=1 and gnt=0 without waiting for CLK. After release, req=1000 grants 1000 with ptr restarted at 0.
- Stuck ack: nBUSACK held low after release → block stays in RELEASE with nBUSRQ=1 and busy=1. Raising nBUSACK resumes GAP then IDLE.
